// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-rate encodings, divisor lookup and transmitter states.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        BAUD24  = 2'b00,
        BAUD48  = 2'b01,
        BAUD96  = 2'b10,
        BAUD192 = 2'b11
    } baud_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Bit-period length in system clocks, rounded to nearest.
    function automatic int unsigned baud_divisor(input int unsigned clk_hz, input baud_e baud);
        int unsigned rate;
        case (baud)
            BAUD24:  rate = 2400;
            BAUD48:  rate = 4800;
            BAUD96:  rate = 9600;
            default: rate = 19200;
        endcase
        return (clk_hz + rate / 2) / rate;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_bit_timer.sv
// 1x bit-period timer: restarts on start, ticks bit_end on the last cycle of each bit.
module uart_tx_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end,
    output logic             bit_pre
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;

    // bit_pre flags the cycle before bit_end so callers can register outputs for that cycle.
    assign bit_end = en && (cnt_q == div_q - DIV_W'(1));
    assign bit_pre = en && (cnt_q == div_q - DIV_W'(2));

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (start) begin
            cnt_d = '0;
            div_d = div;
        end else if (en) begin
            cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int          DIV_W  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  baud_rate,
    input  logic        parity_en,
    input  logic        parity_odd,
    input  logic        stop2,
    uart_tx_if.slave    bus,
    output logic        tx_out,
    output logic        tx_busy,
    output logic        tx_done
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              tx_out_q, tx_out_d;
    logic              tx_ready_q, tx_ready_d;
    logic              tx_busy_q, tx_busy_d;
    logic              tx_done_q, tx_done_d;

    logic             accept;
    logic             bit_end;
    logic             bit_pre;
    logic             last_pre;
    logic [DIV_W-1:0] div_sel;

    assign accept  = bus.tx_valid && tx_ready_q;
    assign div_sel = DIV_W'(baud_divisor(CLK_HZ, baud_e'(baud_rate)));

    uart_tx_bit_timer #(.DIV_W(DIV_W)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .en      (state_q != IDLE),
        .start   (accept),
        .div     (div_sel),
        .bit_end (bit_end),
        .bit_pre (bit_pre)
    );

    // Next cycle is the final cycle of the last stop bit.
    assign last_pre = (state_q == STOP) && (stop_idx_q == stop2_q) && bit_pre;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        tx_out_d   = tx_out_q;
        case (state_q)
            IDLE: ;
            START: if (bit_end) begin
                state_d   = DATA;
                tx_out_d  = shift_q[0];
                shift_d   = shift_q >> 1;
                bit_idx_d = '0;
            end
            DATA: if (bit_end) begin
                if (bit_idx_q == 3'd7) begin
                    if (par_en_q) begin
                        state_d  = PARITY;
                        tx_out_d = par_bit_q;
                    end else begin
                        state_d    = STOP;
                        tx_out_d   = 1'b1;
                        stop_idx_d = 1'b0;
                    end
                end else begin
                    tx_out_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            PARITY: if (bit_end) begin
                state_d    = STOP;
                tx_out_d   = 1'b1;
                stop_idx_d = 1'b0;
            end
            STOP: if (bit_end) begin
                if (stop_idx_q == stop2_q) state_d = IDLE;
                else                       stop_idx_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Acceptance may coincide with the final stop cycle, giving gapless frames.
        if (accept) begin
            state_d   = START;
            tx_out_d  = 1'b0;
            shift_d   = bus.tx_data;
            par_en_d  = parity_en;
            par_bit_d = (^bus.tx_data) ^ parity_odd;
            stop2_d   = stop2;
        end
        tx_busy_d  = (state_d != IDLE);
        tx_ready_d = (state_d == IDLE) || last_pre;
        tx_done_d  = last_pre;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_out_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_out_q   <= tx_out_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_ff @(posedge clock) begin
        shift_q   <= shift_d;
        par_en_q  <= par_en_d;
        par_bit_q <= par_bit_d;
        stop2_q   <= stop2_d;
    end

    assign tx_out       = tx_out_q;
    assign tx_busy      = tx_busy_q;
    assign tx_done      = tx_done_q;
    assign bus.tx_ready = tx_ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx against a frame-level reference model (scaled clock keeps runs short).
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CLK_HZ = 500_000;
    localparam int DIV_W  = 16;

    typedef struct {
        logic [7:0] data;
        logic [1:0] baud;
        logic       par_en;
        logic       par_odd;
        logic       stop2;
    } cfg_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] baud_rate;
    logic       parity_en, parity_odd, stop2;
    logic       tx_out, tx_busy, tx_done;

    int checks   = 0;
    int failures = 0;

    uart_tx_if bus();

    uart_tx #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .baud_rate  (baud_rate),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .bus        (bus),
        .tx_out     (tx_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model_div(input logic [1:0] b);
        int baud;
        baud = 2400 << b;
        return (CLK_HZ + baud / 2) / baud;
    endfunction

    // Line levels of one frame, one entry per bit period; returns number of bits.
    function automatic int build_bits(input cfg_t c, output logic b[12]);
        int n;
        for (int i = 0; i < 12; i++) b[i] = 1'b1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1+i] = c.data[i];
        n = 9;
        if (c.par_en) begin
            b[n] = (^c.data) ^ c.par_odd;
            n++;
        end
        n += c.stop2 ? 2 : 1;
        return n;
    endfunction

    task automatic drive(input cfg_t c, input logic v);
        bus.tx_data  = c.data;
        baud_rate    = c.baud;
        parity_en    = c.par_en;
        parity_odd   = c.par_odd;
        stop2        = c.stop2;
        bus.tx_valid = v;
    endtask

    task automatic rand_cfg(output cfg_t c);
        c.data    = 8'($urandom);
        c.baud    = 2'($urandom);
        c.par_en  = 1'($urandom);
        c.par_odd = 1'($urandom);
        c.stop2   = 1'($urandom);
    endtask

    // mode: 0 valid low, 1 random inputs and valid, 2 valid held high.
    task automatic run_frame(input string tag, input cfg_t cur, input int mode,
                             input bit chain, input cfg_t nxt);
        logic exp_bits[12];
        int nb, div, total, bad, done_pos, done_cnt, ready_cnt, ready_pos, busy_bad;
        cfg_t r;
        nb = build_bits(cur, exp_bits);
        div = model_div(cur.baud);
        total = nb * div;
        done_pos = -1; done_cnt = 0; ready_cnt = 0; ready_pos = -1; busy_bad = 0;
        for (int b = 0; b < nb; b++) begin
            bad = 0;
            for (int j = 0; j < div; j++) begin
                int k;
                k = b * div + j;
                @(negedge clock);
                if (tx_out !== exp_bits[b]) bad++;
                if (tx_done === 1'b1) begin
                    done_cnt++;
                    if (done_pos < 0) done_pos = k;
                end
                if (bus.tx_ready === 1'b1) begin
                    ready_cnt++;
                    if (ready_pos < 0) ready_pos = k;
                end
                if (tx_busy !== 1'b1) busy_bad++;
                if (k == total - 1) begin
                    if (chain) drive(nxt, 1'b1);
                    else bus.tx_valid = 1'b0;
                end else if (mode == 1) begin
                    rand_cfg(r);
                    drive(r, 1'($urandom));
                end else begin
                    bus.tx_valid = (mode == 2);
                end
            end
            chk($sformatf("%s_bit%0d", tag, b), bad, 0);
        end
        chk({tag, "_done_pos"}, done_pos, total - 1);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_ready_pos"}, ready_pos, total - 1);
        chk({tag, "_ready_cnt"}, ready_cnt, 1);
        chk({tag, "_busy"}, busy_bad, 0);
    endtask

    task automatic check_idle(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (tx_out !== 1'b1 || bus.tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0)
                bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_t c, n;
        bit   pending, chain;
        int   done_seen;

        reset = 1'b1;
        c = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0};
        drive(c, 1'b0);
        repeat (3) @(negedge clock);
        chk("rst_tx_out", tx_out, 1);
        chk("rst_ready", bus.tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        reset = 1'b0;
        check_idle("idle100", 100);

        chk("div_2400", baud_divisor(50_000_000, BAUD24), 20833);
        chk("div_4800", baud_divisor(50_000_000, BAUD48), 10417);
        chk("div_9600", baud_divisor(50_000_000, BAUD96), 5208);
        chk("div_19200", baud_divisor(50_000_000, BAUD192), 2604);

        c = '{8'h55, 2'b11, 1'b0, 1'b0, 1'b0};
        drive(c, 1'b1);
        run_frame("basic55", c, 0, 1'b0, c);
        check_idle("post_basic", 5);

        c = '{8'h07, 2'b10, 1'b1, 1'b0, 1'b0};
        drive(c, 1'b1);
        run_frame("par_even", c, 0, 1'b0, c);
        check_idle("post_even", 5);
        c = '{8'h07, 2'b10, 1'b1, 1'b1, 1'b0};
        drive(c, 1'b1);
        run_frame("par_odd", c, 0, 1'b0, c);
        check_idle("post_odd", 5);
        c = '{8'h07, 2'b10, 1'b1, 1'b0, 1'b1};
        drive(c, 1'b1);
        run_frame("stop2", c, 0, 1'b0, c);
        check_idle("post_stop2", 5);

        c = '{8'hA3, 2'b00, 1'b0, 1'b0, 1'b0};
        n = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b0};
        drive(c, 1'b1);
        run_frame("b2b_a", c, 2, 1'b1, n);
        run_frame("b2b_b", n, 0, 1'b0, n);
        check_idle("post_b2b", 5);

        c = '{8'h9E, 2'b11, 1'b1, 1'b0, 1'b1};
        drive(c, 1'b1);
        run_frame("perturb", c, 1, 1'b0, c);
        check_idle("no_extra", 300);

        // Abort in data bit 3 (bit slot 4) of a 9600 frame.
        c = '{8'hC6, 2'b10, 1'b1, 1'b1, 1'b1};
        drive(c, 1'b1);
        done_seen = 0;
        for (int i = 0; i < 4 * 52 + 20; i++) begin
            @(negedge clock);
            bus.tx_valid = 1'b0;
            if (tx_done === 1'b1) done_seen++;
        end
        chk("mid_databit3", tx_out, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_tx_out", tx_out, 1);
        chk("mid_rst_ready", bus.tx_ready, 1);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_done", done_seen + int'(tx_done), 0);
        reset = 1'b0;
        c = '{8'h96, 2'b11, 1'b0, 1'b0, 1'b0};
        drive(c, 1'b1);
        run_frame("after_rst", c, 0, 1'b0, c);
        check_idle("post_after_rst", 60);

        pending = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (!pending) begin
                rand_cfg(c);
                drive(c, 1'b1);
            end
            chain = (i < 14) && 1'($urandom);
            rand_cfg(n);
            run_frame($sformatf("rnd%0d", i), c, int'($urandom_range(0, 1)), chain, n);
            if (chain) c = n;
            else check_idle($sformatf("rnd%0d_idle", i), 3);
            pending = chain;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
